// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence transmitter and the detector benches that it drives.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;

    // Transmitter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Default geometry
    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 4;

    // Standard stimulus patterns used by the detector benches
    localparam logic [3:0] PAT_1101 = 4'b1101;
    localparam logic [3:0] PAT_1011 = 4'b1011;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a PAT_W-bit pattern out MSB-first, reps times, with gap idle cycles between repetitions.
// Latency: first pattern bit is registered on the same edge that accepts start; done pulses one cycle after the last bit.
// Backpressure: none on the serial side; start is accepted only in IDLE, and a start while busy is dropped, not queued.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, abort           control; abort beats start, rst beats both
//   pattern, reps, gap     transfer parameters, captured on an accepted start
//   idle_bit               line level outside pattern bits, captured on an accepted start
//   ser_out, valid         serial bit and its qualifier (registered)
//   busy, done             transfer in progress / one-cycle completion pulse (registered)
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic [CNT_W-1:0] gap,
    input  logic             idle_bit,
    output logic             ser_out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(PAT_W);

    seq_state_t       r_state;
    logic [PAT_W-1:0] r_pat;      // captured pattern, used to reload between repetitions
    logic [PAT_W-1:0] r_shift;    // bits still to be sent, next one at the MSB
    logic [BIT_W-1:0] r_bit_cnt;  // bits remaining after the one on ser_out
    logic [CNT_W-1:0] r_rep_cnt;  // repetitions remaining, including the current one
    logic [CNT_W-1:0] r_gap_len;
    logic [CNT_W-1:0] r_gap_cnt;  // gap cycles remaining after the current one
    logic             r_idle;
    logic             r_ser;
    logic             r_vld;
    logic             r_busy;
    logic             r_done;

    logic w_accept;

    assign w_accept = start & ~abort;

    assign ser_out = r_ser;
    assign valid   = r_vld;
    assign busy    = r_busy;
    assign done    = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pat     <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_rep_cnt <= '0;
            r_gap_len <= '0;
            r_gap_cnt <= '0;
            r_idle    <= 1'b0;
            r_ser     <= 1'b0;
            r_vld     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_pat     <= pattern;
                        r_gap_len <= gap;
                        r_idle    <= idle_bit;
                        r_rep_cnt <= reps;
                        r_busy    <= 1'b1;
                        if (reps != '0) begin
                            // MSB goes straight onto the line; the rest waits in the shifter
                            r_state   <= SHIFT;
                            r_ser     <= pattern[PAT_W-1];
                            r_shift   <= pattern << 1;
                            r_bit_cnt <= BIT_W'(PAT_W - 1);
                            r_vld     <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_ser   <= idle_bit;
                            r_vld   <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end

                SHIFT: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_ser   <= r_idle;
                        r_vld   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_bit_cnt != '0) begin
                        r_ser     <= r_shift[PAT_W-1];
                        r_shift   <= r_shift << 1;
                        r_bit_cnt <= r_bit_cnt - BIT_W'(1);
                    end else if (r_rep_cnt > CNT_W'(1)) begin
                        // last bit of a repetition is on the line and more remain
                        r_rep_cnt <= r_rep_cnt - CNT_W'(1);
                        if (r_gap_len == '0) begin
                            r_ser     <= r_pat[PAT_W-1];
                            r_shift   <= r_pat << 1;
                            r_bit_cnt <= BIT_W'(PAT_W - 1);
                        end else begin
                            r_state   <= GAP;
                            r_gap_cnt <= r_gap_len - CNT_W'(1);
                            r_ser     <= r_idle;
                            r_vld     <= 1'b0;
                        end
                    end else begin
                        r_state   <= DONE;
                        r_rep_cnt <= '0;
                        r_ser     <= r_idle;
                        r_vld     <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end

                GAP: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_ser   <= r_idle;
                        r_vld   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_gap_cnt == '0) begin
                        r_state   <= SHIFT;
                        r_ser     <= r_pat[PAT_W-1];
                        r_shift   <= r_pat << 1;
                        r_bit_cnt <= BIT_W'(PAT_W - 1);
                        r_vld     <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - CNT_W'(1);
                    end
                end

                DONE: begin
                    // abort is ignored here so the done pulse always completes
                    r_state <= IDLE;
                    r_ser   <= r_idle;
                    r_vld   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_vld   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed test-plan cases plus randomized transfers against a cycle-stream model.
// Latency: sample k of a transfer is taken 1 ns after the k-th edge counted from the accepting edge (k=0).
// Backpressure: start is held high while the model says busy, which the DUT must ignore.
module tb_seq_pattern_tx;
    import seq_pkg::*;

    localparam int PW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [PW-1:0] pattern = '0;
    logic [CW-1:0] reps = '0;
    logic [CW-1:0] gap = '0;
    logic          idle_bit = 1'b0;
    logic          ser_out;
    logic          valid;
    logic          busy;
    logic          done;

    int n_chk  = 0;
    int n_pass = 0;
    int xfer_id = 0;

    typedef struct packed {
        logic ser;
        logic vld;
        logic bsy;
        logic dn;
    } smp_t;

    seq_pattern_tx #(.PAT_W(PW), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .pattern  (pattern),
        .reps     (reps),
        .gap      (gap),
        .idle_bit (idle_bit),
        .ser_out  (ser_out),
        .valid    (valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic chk_smp(input string tag, input smp_t e);
        chk({tag, " ser"},   32'(ser_out), 32'(e.ser));
        chk({tag, " valid"}, 32'(valid),   32'(e.vld));
        chk({tag, " busy"},  32'(busy),    32'(e.bsy));
        chk({tag, " done"},  32'(done),    32'(e.dn));
    endtask

    // One transfer. abort_at / rst_at >= 0 inject abort / reset before the edge following that sample.
    task automatic run_xfer(input logic [PW-1:0] p, input int r, input int g, input logic ib,
                            input int abort_at, input int rst_at);
        smp_t q[$];
        int   busy_n = 0;
        int   done_n = 0;
        bit   cut = 0;
        xfer_id++;

        // Expected line activity from the accepting edge onward
        if (r == 0) begin
            q.push_back('{ser: ib, vld: 1'b0, bsy: 1'b1, dn: 1'b1});
        end else begin
            for (int i = 0; i < r; i++) begin
                for (int b = PW - 1; b >= 0; b--)
                    q.push_back('{ser: p[b], vld: 1'b1, bsy: 1'b1, dn: 1'b0});
                if (i != r - 1)
                    for (int j = 0; j < g; j++)
                        q.push_back('{ser: ib, vld: 1'b0, bsy: 1'b1, dn: 1'b0});
            end
            q.push_back('{ser: ib, vld: 1'b0, bsy: 1'b1, dn: 1'b1});
        end
        q.push_back('{ser: ib, vld: 1'b0, bsy: 1'b0, dn: 1'b0});

        pattern  = p;
        reps     = CW'(r);
        gap      = CW'(g);
        idle_bit = ib;
        start    = 1'b1;
        abort    = 1'b0;

        for (int k = 0; k < q.size(); k++) begin
            step();
            chk_smp($sformatf("x%0d.c%0d", xfer_id, k), q[k]);
            if (busy) busy_n++;
            if (done) done_n++;
            // scramble captured inputs; keep start asserted while busy (must be ignored)
            start    = q[k].bsy;
            pattern  = PW'($urandom);
            reps     = CW'($urandom);
            gap      = CW'($urandom);
            idle_bit = 1'($urandom);
            if (k == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                start = 1'b0;
                chk_smp($sformatf("x%0d.abort", xfer_id), '{ser: ib, vld: 1'b0, bsy: 1'b0, dn: 1'b0});
                cut = 1;
                break;
            end
            if (k == rst_at) begin
                rst   = 1'b1;
                start = 1'b1;
                step();
                chk_smp($sformatf("x%0d.rst0", xfer_id), '{default: 1'b0});
                step();
                chk_smp($sformatf("x%0d.rst1", xfer_id), '{default: 1'b0});
                rst   = 1'b0;
                start = 1'b0;
                cut = 1;
                break;
            end
        end
        start = 1'b0;
        if (!cut) begin
            chk($sformatf("x%0d busy_cycles", xfer_id), 32'(busy_n),
                32'((r == 0) ? 1 : r * PW + (r - 1) * g + 1));
            chk($sformatf("x%0d done_count", xfer_id), 32'(done_n), 32'd1);
        end
    endtask

    initial begin
        // reset state
        step();
        chk_smp("reset", '{default: 1'b0});
        step();
        rst = 1'b0;
        step();
        chk_smp("post_reset_idle", '{default: 1'b0});

        // directed cases from the test plan
        run_xfer(PAT_1101, 1, 0, 1'b0, -1, -1);
        run_xfer(PAT_1101, 3, 0, 1'b0, -1, -1);
        run_xfer(PAT_1011, 2, 2, 1'b1, -1, -1);
        run_xfer(PAT_1101, 0, 0, 1'b0, -1, -1);
        run_xfer(PAT_1101, 2, 0, 1'b1, 1, -1);   // abort while 2nd bit on the line
        run_xfer(PAT_1011, 1, 0, 1'b0, -1, -1);  // fresh transfer right after abort
        run_xfer(PAT_1011, 2, 3, 1'b1, 6, -1);   // abort in GAP
        run_xfer(PAT_1101, 1, 0, 1'b1, 4, -1);   // abort in DONE: pulse completes

        // abort in IDLE blocks start
        pattern = PAT_1101;
        reps    = 4'd2;
        start   = 1'b1;
        abort   = 1'b1;
        step();
        start   = 1'b0;
        abort   = 1'b0;
        chk("idle_abort busy", 32'(busy), 32'd0);
        chk("idle_abort valid", 32'(valid), 32'd0);
        step();
        chk("idle_abort busy2", 32'(busy), 32'd0);

        // reset mid-GAP with start held high across it
        run_xfer(PAT_1011, 2, 3, 1'b1, -1, 5);
        run_xfer(PAT_1101, 1, 1, 1'b0, -1, -1);

        // randomized transfers, occasional abort
        for (int t = 0; t < 40; t++) begin
            logic [PW-1:0] p;
            int r;
            int g;
            int ab;
            p  = PW'($urandom);
            r  = $urandom_range(0, 5);
            g  = $urandom_range(0, 4);
            ab = -1;
            if (r > 0 && $urandom_range(0, 4) == 0)
                ab = $urandom_range(0, r * PW + (r - 1) * g);
            run_xfer(p, r, g, 1'($urandom), ab, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
